// File: rtl/jk_counter_bank_pkg.sv
// Shared definitions for the JK counter bank: mode encoding and width limit.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_MODE_JK   = 2'd0,
        JK_MODE_UP   = 2'd1,
        JK_MODE_DOWN = 2'd2,
        JK_MODE_LOAD = 2'd3
    } jk_mode_e;

    localparam int unsigned JK_MAX_WIDTH = 32;

endpackage

// File: rtl/jk_counter_bank_if.sv
// Control/status bundle of the JK counter bank; master drives controls, slave drives state.
interface jk_counter_bank_if
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    jk_mode_e         mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic             tc;
    logic             wrap;

    modport master (
        output en, mode, j, k, d,
        input  q, q_bar, tc, wrap
    );

    modport slave (
        input  en, mode, j, k, d,
        output q, q_bar, tc, wrap
    );
endinterface

// File: rtl/jk_counter_bank_cell.sv
// Single JK flip-flop with synchronous reset to a per-bit value and an update enable.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);
    logic q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= rst_val;
        end else if (en) begin
            case ({j, k})
                2'b01:   q_q <= 1'b0;
                2'b10:   q_q <= 1'b1;
                2'b11:   q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q     = q_q;
    assign q_bar = ~q_q;
endmodule

// File: rtl/jk_counter_bank.sv
// WIDTH-bit bank of JK cells: per-bit JK, up/down count via toggle chains, parallel load.
// Define JK_COUNTER_SAT_EN to saturate at the count limits instead of wrapping.
module jk_counter_bank
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter logic [31:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    jk_counter_bank_if.slave  bus
);
    localparam logic [WIDTH-1:0] RST_V = RESET_VAL[WIDTH-1:0];
`ifdef JK_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic [WIDTH-1:0] q, q_bar, t_up, t_dn, cell_j, cell_k;
    logic             at_max, at_min, up_act, dn_act, wrap_d, wrap_q;

    assign at_max = &q;
    assign at_min = ~|q;
    assign up_act = bus.en && (bus.mode == JK_MODE_UP);
    assign dn_act = bus.en && (bus.mode == JK_MODE_DOWN);

    // Ripple toggle enables: bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        t_up    = '0;
        t_dn    = '0;
        t_up[0] = 1'b1;
        t_dn[0] = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            t_up[i] = t_up[i-1] & q[i-1];
            t_dn[i] = t_dn[i-1] & ~q[i-1];
        end
    end

    always_comb begin
        cell_j = bus.j;
        cell_k = bus.k;
        case (bus.mode)
            JK_MODE_UP: begin
                cell_j = (SAT && at_max) ? '0 : t_up;
                cell_k = cell_j;
            end
            JK_MODE_DOWN: begin
                cell_j = (SAT && at_min) ? '0 : t_dn;
                cell_k = cell_j;
            end
            JK_MODE_LOAD: begin
                cell_j = bus.d;
                cell_k = ~bus.d;
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RST_V[i]),
            .en      (bus.en),
            .j       (cell_j[i]),
            .k       (cell_k[i]),
            .q       (q[i]),
            .q_bar   (q_bar[i])
        );
    end

    assign wrap_d = !SAT && ((up_act && at_max) || (dn_act && at_min));

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign bus.q     = q;
    assign bus.q_bar = q_bar;
    assign bus.tc    = !rst && ((up_act && at_max) || (dn_act && at_min));
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_jk_counter_bank.sv
// Directed self-checking bench for jk_counter_bank (WIDTH=4, RESET_VAL=4'hA).
module tb_jk_counter_bank;
    import jk_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    jk_counter_bank_if #(.WIDTH(4)) bus ();

    jk_counter_bank #(
        .WIDTH     (4),
        .RESET_VAL (32'hA)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] eq, input logic ew, input logic etc);
        check({tag, ".q"}, {28'd0, bus.q}, {28'd0, eq});
        check({tag, ".q_bar"}, {28'd0, bus.q_bar}, {28'd0, ~eq});
        check({tag, ".wrap"}, {31'd0, bus.wrap}, {31'd0, ew});
        check({tag, ".tc"}, {31'd0, bus.tc}, {31'd0, etc});
    endtask

    initial begin
        rst      = 1'b1;
        bus.en   = 1'b1;
        bus.mode = JK_MODE_UP;
        bus.j    = '0;
        bus.k    = '0;
        bus.d    = '0;

        // Reset with en=1/UP: rst dominates, tc held low while rst=1
        step();
        check_state("reset", 4'hA, 1'b0, 1'b0);
        step();
        check_state("reset2", 4'hA, 1'b0, 1'b0);
        rst = 1'b0;

        // Clear to zero via LOAD, then JK operations
        bus.mode = JK_MODE_LOAD;
        bus.d    = 4'h0;
        #1 check("load_tc", {31'd0, bus.tc}, 32'd0);
        step();
        check_state("load0", 4'h0, 1'b0, 1'b0);

        bus.mode = JK_MODE_JK;
        bus.j    = 4'b1010;
        bus.k    = 4'b0001;
        step();
        check_state("jk_set", 4'b1010, 1'b0, 1'b0);
        bus.j = 4'b1111;
        bus.k = 4'b1111;
        step();
        check_state("jk_tog", 4'b0101, 1'b0, 1'b0);
        bus.en = 1'b0;
        bus.mode = JK_MODE_UP;
        for (int i = 0; i < 3; i++) begin
            step();
            check_state("hold", 4'b0101, 1'b0, 1'b0);
        end
        bus.en = 1'b1;

        // UP through the all-ones boundary
        bus.mode = JK_MODE_LOAD;
        bus.d    = 4'hE;
        step();
        check_state("loadE", 4'hE, 1'b0, 1'b0);
        bus.mode = JK_MODE_UP;
        #1 check("up_tc_E", {31'd0, bus.tc}, 32'd0);
        step();
        check_state("up_F", 4'hF, 1'b0, 1'b1);
        step();
`ifdef JK_COUNTER_SAT_EN
        check_state("up_sat1", 4'hF, 1'b0, 1'b1);
        step();
        check_state("up_sat2", 4'hF, 1'b0, 1'b1);
`else
        check_state("up_wrap", 4'h0, 1'b1, 1'b0);
        step();
        check_state("up_1", 4'h1, 1'b0, 1'b0);
`endif

        // DOWN through zero
        bus.mode = JK_MODE_LOAD;
        bus.d    = 4'h1;
        step();
        check_state("load1", 4'h1, 1'b0, 1'b0);
        bus.mode = JK_MODE_DOWN;
        #1 check("dn_tc_1", {31'd0, bus.tc}, 32'd0);
        step();
        check_state("dn_0", 4'h0, 1'b0, 1'b1);
        step();
`ifdef JK_COUNTER_SAT_EN
        check_state("dn_sat", 4'h0, 1'b0, 1'b1);
`else
        check_state("dn_wrap", 4'hF, 1'b1, 1'b0);
`endif
        bus.en = 1'b0;
        #1 check("dn_tc_en0", {31'd0, bus.tc}, 32'd0);
        step();
        check("wrap_en0", {31'd0, bus.wrap}, 32'd0);
        bus.en = 1'b1;

        // Reset mid-count discards the pending increment
        bus.mode = JK_MODE_LOAD;
        bus.d    = 4'h6;
        step();
        bus.mode = JK_MODE_UP;
        step();
        check_state("up_7", 4'h7, 1'b0, 1'b0);
        rst = 1'b1;
        #1 check("rst_tc", {31'd0, bus.tc}, 32'd0);
        step();
        check_state("mid_rst", 4'hA, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check_state("after_rst", 4'hB, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jk_counter_bank.md
Name: jk_counter_bank

Overview:
- WIDTH-bit register built from JK cells. It runs in one of four modes: per-bit JK, synchronous up-count, synchronous down-count, parallel load.
- Next generation of the single JK flip-flop. Adds a vector width, synchronous reset, enable, counting modes driven through JK toggle logic, and terminal-count and wrap flags.
- Sits as a general-purpose state/count element in small control datapaths.

Parameters:
- WIDTH, 4, number of JK cells / counter bits (legal range 1 to 32).
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits; upper bits truncated).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  update enable; when low, all state holds.
- mode  input  2  0=JK, 1=UP, 2=DOWN, 3=LOAD.
- j  input  WIDTH  per-bit J, used in JK mode only.
- k  input  WIDTH  per-bit K, used in JK mode only.
- d  input  WIDTH  load value, used in LOAD mode only.
- q  output  WIDTH  register state.
- q_bar  output  WIDTH  always the bitwise inverse of q, including during reset.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse.

Behaviour:
- Reset:
  - All state changes on the rising edge of clk only.
  - rst=1 at an edge: q<=RESET_VAL, q_bar<=~RESET_VAL, wrap<=0.
  - rst has priority over en and mode.
  - Reset asserted mid-count discards the pending update.
  - No asynchronous path.
- Enable: en=0 with rst=0 means q holds and wrap<=0. Inputs are ignored.
- JK mode (en=1, mode=0), per bit i:
  - j=0,k=0: hold.
  - j=0,k=1: clear.
  - j=1,k=0: set.
  - j=1,k=1: toggle.
  - wrap<=0.
- UP mode (en=1, mode=1):
  - Each cell is driven with J=K=t_i, where t_0=1 and t_i = AND of q[i-1:0].
  - Result: q<=q+1 modulo 2^WIDTH.
  - Wrap event: q was all-ones and becomes 0. wrap<=1 on that edge, otherwise 0.
- DOWN mode (en=1, mode=2):
  - Each cell is driven with J=K=t_i, where t_0=1 and t_i = AND of ~q[i-1:0].
  - Result: q<=q-1 modulo 2^WIDTH.
  - Wrap event: q was 0 and becomes all-ones. wrap<=1 on that edge, otherwise 0.
- LOAD mode (en=1, mode=3): q<=d; wrap<=0.
- tc:
  - tc = en & ((mode==UP & q==all-ones) | (mode==DOWN & q==0)).
  - tc=0 in the JK and LOAD modes.
  - tc=0 while rst=1.
- Mode changes take effect on the same edge they are sampled; no pipeline.
- Latency: 1 cycle from input to q.
- WIDTH=1: UP and DOWN both toggle. tc is q in UP mode and ~q in DOWN mode (each gated by en).
- Invariant: q_bar == ~q at every cycle.

Optional Feature:
- Macro: JK_COUNTER_SAT_EN.
- Defined:
  - UP at all-ones holds at all-ones; DOWN at 0 holds at 0. The toggle enables are forced to 0 in this condition.
  - wrap never asserts (tied 0).
  - tc still asserts at the limit.
- Undefined: modulo wrap as specified above, and wrap pulses on each wrap event.

Decomposition:
- Shared package jk_pkg holds:
  - the mode enum: JK_MODE_JK=2'd0, JK_MODE_UP=2'd1, JK_MODE_DOWN=2'd2, JK_MODE_LOAD=2'd3;
  - the WIDTH legality limit, 32.
- Sub-module jk_cell: one bit with inputs clk, rst, rst_val, en, j, k, and outputs q, q_bar.
  - Instantiated WIDTH times via generate.
  - The top level computes the per-bit J/K from mode, implementing LOAD as j=d_i, k=~d_i.

Test Plan:
- Reset: WIDTH=4, RESET_VAL=4'hA, rst=1 for one edge with en=1, mode=UP -> q=4'hA, q_bar=4'h5, wrap=0, tc=0.
- JK mode from q=4'b0000:
  - j=4'b1010, k=4'b0001 -> q=4'b1010.
  - Then j=4'b1111, k=4'b1111 -> q=4'b0101.
  - Then en=0 for 3 edges -> q stays 4'b0101.
- UP wrap:
  - LOAD d=4'hE, then UP for 3 edges -> q=F, 0, 1.
  - tc=1 while q=F.
  - wrap=1 for exactly the one cycle after the F->0 edge.
- DOWN wrap: LOAD d=4'h1, then DOWN for 2 edges -> q=0 (tc=1), then F with a wrap pulse.
- Reset mid-count: UP counting at q=4'h7, assert rst on the edge -> q=RESET_VAL, not 8.
- JK_COUNTER_SAT_EN defined: UP from 4'hE for 4 edges -> E, F, F, F; wrap stays 0; tc=1 from q=F onward.
